cpu_md_sequencer: RTL and testbench

Multi-cycle controller for the RV32IM M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the single-cycle core. It sits beside the R-type datapath ALU and is selected when the decoder asserts the MD select. It sequences a registered multiplier and a radix-2 restoring divider. While it works, it stalls the PC write enable and gates register writeback, then delivers one result with a one-cycle write strobe.

---
 rtl/cpu_md_sequencer_if.sv | 28 ++
 rtl/cpu_md_sequencer.sv | 147 ++++++++++++++
 tb/tb_cpu_md_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_md_sequencer_if.sv
// Datapath <-> M-extension sequencer signal bundle.
// Handshake: the datapath raises MD_Valid with operands and holds it (operands
// only need to be stable in the first cycle) until it samples MD_Done; the
// sequencer answers with MD_Done/MD_RegWrite for exactly one cycle, and MD_Valid
// seen during that DONE cycle is ignored, so the next op starts the cycle after.
interface cpu_md_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MD_Valid;
    logic [2:0]            MD_Funct3;
    logic [DATA_WIDTH-1:0] MD_Op1;
    logic [DATA_WIDTH-1:0] MD_Op2;
    logic                  MD_PCWrite;
    logic                  MD_RegWrite;
    logic [DATA_WIDTH-1:0] MD_Result;
    logic                  MD_Busy;
    logic                  MD_Done;

    modport master (
        output MD_Valid, MD_Funct3, MD_Op1, MD_Op2,
        input  MD_PCWrite, MD_RegWrite, MD_Result, MD_Busy, MD_Done
    );

    modport slave (
        input  MD_Valid, MD_Funct3, MD_Op1, MD_Op2,
        output MD_PCWrite, MD_RegWrite, MD_Result, MD_Busy, MD_Done
    );
endinterface

// File: rtl/cpu_md_sequencer.sv
// RV32IM multiply/divide sequencer: one-cycle registered multiply and a
// radix-2 restoring divider, stalling the PC until the result is written.
module cpu_md_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                CPU_clk,
    input  logic                CPU_rst,
    cpu_md_sequencer_if.slave   md,
    output logic [1:0]          dbg_state_o
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            f3_q, f3_d;       // funct3[1:0]; funct3[2] only steers IDLE
    logic [DATA_WIDTH-1:0] op1_q, op1_d;     // multiplicand, or dividend shifting into quotient
    logic [DATA_WIDTH-1:0] op2_q, op2_d;     // multiplier, or divisor magnitude
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  neg_q, neg_d;     // divide result needs negation
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  in_signed, div_zero, div_ovf, special;
    logic [DATA_WIDTH-1:0] special_res;
    logic [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
    logic [DATA_WIDTH-1:0] mul_res;
    logic [DATA_WIDTH:0]   rem_sh, diff;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_nx, quo_nx, div_raw, div_res;

    // Datapath: special-case detection, product, one restoring-divide step
    always_comb begin
        in_signed   = ~md.MD_Funct3[0];
        div_zero    = (md.MD_Op2 == '0);
        div_ovf     = in_signed && (md.MD_Op1 == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                                && (md.MD_Op2 == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = md.MD_Funct3[1] ? md.MD_Op1 : '1;
        else if (div_ovf)
            special_res = md.MD_Funct3[1] ? '0 : md.MD_Op1;

        // 00/01/10 treat rs1 as signed, 00/01 treat rs2 as signed
        a_ext   = {{DATA_WIDTH{(f3_q != 2'b11) & op1_q[DATA_WIDTH-1]}}, op1_q};
        b_ext   = {{DATA_WIDTH{~f3_q[1] & op2_q[DATA_WIDTH-1]}}, op2_q};
        prod    = a_ext * b_ext;
        mul_res = (f3_q == 2'b00) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];

        rem_sh  = {rem_q, op1_q[DATA_WIDTH-1]};
        diff    = rem_sh - {1'b0, op2_q};
        q_bit   = ~diff[DATA_WIDTH];
        rem_nx  = q_bit ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
        quo_nx  = {op1_q[DATA_WIDTH-2:0], q_bit};
        div_raw = f3_q[1] ? rem_nx : quo_nx;
        div_res = neg_q ? (~div_raw + 1'b1) : div_raw;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (md.MD_Valid) begin
                if (!md.MD_Funct3[2]) state_d = S_MUL;
                else if (special)     state_d = S_DONE;
                else                  state_d = S_DIV;
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latching and per-state datapath register updates
    always_comb begin
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: if (md.MD_Valid) begin
                f3_d  = md.MD_Funct3[1:0];
                cnt_d = CW'(DATA_WIDTH - 1);
                rem_d = '0;
                neg_d = 1'b0;
                op1_d = md.MD_Op1;
                op2_d = md.MD_Op2;
                if (md.MD_Funct3[2] && in_signed) begin
                    // divider works on magnitudes; sign restored on the way to DONE
                    op1_d = md.MD_Op1[DATA_WIDTH-1] ? (~md.MD_Op1 + 1'b1) : md.MD_Op1;
                    op2_d = md.MD_Op2[DATA_WIDTH-1] ? (~md.MD_Op2 + 1'b1) : md.MD_Op2;
                    neg_d = md.MD_Funct3[1] ? md.MD_Op1[DATA_WIDTH-1]
                                            : (md.MD_Op1[DATA_WIDTH-1] ^ md.MD_Op2[DATA_WIDTH-1]);
                end
                if (md.MD_Funct3[2] && special)
                    result_d = special_res;
            end
            S_MUL: result_d = mul_res;
            S_DIV: begin
                op1_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0)
                    result_d = div_res;
            end
            default: ;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge CPU_clk or posedge CPU_rst) begin
        if (CPU_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // Outputs decoded from state; PC stalls from acceptance until DONE
    always_comb begin
        md.MD_Busy     = (state_q == S_MUL) || (state_q == S_DIV);
        md.MD_Done     = (state_q == S_DONE);
        md.MD_RegWrite = (state_q == S_DONE);
        md.MD_Result   = result_q;
        md.MD_PCWrite  = CPU_rst || !(((state_q == S_IDLE) && md.MD_Valid) || md.MD_Busy);
        dbg_state_o    = state_q;
    end
endmodule

// File: tb/tb_cpu_md_sequencer.sv
module tb_cpu_md_sequencer;
    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_md_sequencer_if #(.DATA_WIDTH(W)) md();
    logic [1:0] dbg_state;

    cpu_md_sequencer #(.DATA_WIDTH(W)) dut (
        .CPU_clk     (clk),
        .CPU_rst     (rst),
        .md          (md),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: RISC-V M-extension semantics with plain arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (f)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle index of DONE, counted from the accepting IDLE cycle
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 2;
        if (b == 0) return 1;
        if (!f[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every write strobe against the scoreboard
    always @(negedge clk) begin
        if (md.MD_RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_regwrite: got strobe with result %h, required no strobe", md.MD_Result);
            end else begin
                check("result", md.MD_Result, exp_q.pop_front());
            end
        end
    end

    // Driver: issues one op and checks cycle-by-cycle handshake timing.
    // Returns with the op in DONE, so the next call starts back to back.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at);
        int lat;
        lat = ref_lat(f, a, b);
        @(negedge clk);
        md.MD_Valid  = 1'b1;
        md.MD_Funct3 = f;
        md.MD_Op1    = a;
        md.MD_Op2    = b;
        exp_q.push_back(ref_md(f, a, b));
        #1;
        check("pcwrite_c0", md.MD_PCWrite, 0);
        check("busy_c0", md.MD_Busy, 0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            // operands are only meaningful in the accepting cycle
            md.MD_Op1    = $urandom;
            md.MD_Op2    = $urandom;
            md.MD_Funct3 = 3'($urandom_range(0, 7));
            #1;
            check("done_timing", md.MD_Done, (c == lat));
            check("pcwrite_timing", md.MD_PCWrite, (c == lat));
            check("busy_timing", md.MD_Busy, (c < lat));
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", md.MD_Busy, 0);
                check("rst_done", md.MD_Done, 0);
                check("rst_regwrite", md.MD_RegWrite, 0);
                check("rst_pcwrite", md.MD_PCWrite, 1);
                void'(exp_q.pop_back());
                md.MD_Valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (c == lat) md.MD_Valid = 1'b0;
        end
    endtask

    initial begin
        rst          = 1'b1;
        md.MD_Valid  = 1'b0;
        md.MD_Funct3 = 3'd0;
        md.MD_Op1    = '0;
        md.MD_Op2    = '0;
        #1;
        check("reset_busy", md.MD_Busy, 0);
        check("reset_done", md.MD_Done, 0);
        check("reset_regwrite", md.MD_RegWrite, 0);
        check("reset_result", md.MD_Result, 0);
        check("reset_pcwrite", md.MD_PCWrite, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, MIN, 32'hFFFF_FFFF, 0);
        run_op(3'd6, MIN, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'd12, 32'd13, 0);     // MUL then DIV back to back
        run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 0);

        // reset in DIV cycle 10 aborts the op, then a fresh DIVU
        run_op(3'd5, 32'd1000, 32'd3, 10);
        repeat (2) @(negedge clk);
        run_op(3'd5, 32'd9, 32'd2, 0);

        // randomized ops, sometimes with idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(f, a, b, 0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
